// File: rtl/wild_cube_pkg.sv
// Shared types, widths and helpers for the wild_cube game-control logic.
package wild_cube_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PLAY,
      HIT,
      OVER
   } game_state_t;

   localparam int unsigned ScoreW = 8;
   localparam int unsigned LivesW = 3;

   function automatic logic [ScoreW-1:0] score_sat_inc(input logic [ScoreW-1:0] i_val);
      return (i_val == '1) ? i_val : i_val + ScoreW'(1);
   endfunction

endpackage

// File: rtl/frame_divider.sv
// Modulo-N counter advanced by an enable (normally a gated frame_tick), with a synchronous
// clear and a terminal-count pulse on the enabled cycle that wraps the count.
module frame_divider #(
   parameter int unsigned N = 8
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_en,
   input  logic i_clear,
   output logic o_tc
);

   localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CntW-1:0] Last = CntW'(N - 1);

   logic [CntW-1:0] r_count;
   logic [CntW-1:0] w_count_d;

   // Terminal count ignores i_clear so callers can combine it with clear-driving logic freely.
   assign o_tc = i_en & (r_count == Last);

   always_comb begin
      w_count_d = r_count;
      if (i_clear) begin
         w_count_d = '0;
      end else if (i_en) begin
         w_count_d = o_tc ? '0 : r_count + CntW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_d;
      end
   end

endmodule

// File: rtl/wall_collision_monitor.sv
// Game-control stage: detects cube/wall overlap once per frame, sequences play/hit/game-over
// and drives the wall-stage controls, score and lives.
module wall_collision_monitor
   import wild_cube_pkg::*;
#(
   parameter int unsigned NUM_WALLS    = 4,
   parameter int unsigned LIVES        = 3,
   parameter int unsigned SCORE_FRAMES = 60,
   parameter int unsigned HIT_FRAMES   = 120,
   parameter int unsigned FLASH_FRAMES = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 frame_tick,
   input  logic                 btn_start,
   input  logic [NUM_WALLS-1:0] wall_px,
   input  logic                 cube_px,
   output logic                 start_machine,
   output logic                 load_counter,
   output logic                 stop,
   output logic                 flash,
   output logic [LivesW-1:0]    lives,
   output logic [ScoreW-1:0]    score,
   output logic                 game_over
);

   game_state_t       r_state;
   game_state_t       w_state_d;
   logic              r_btn_q;
   logic              r_hit_acc;
   logic              w_hit_acc_d;
   logic [LivesW-1:0] r_lives;
   logic [LivesW-1:0] w_lives_d;
   logic [ScoreW-1:0] r_score;
   logic [ScoreW-1:0] w_score_d;
   logic              r_flash;
   logic              w_flash_d;
   logic              r_start_machine;
   logic              r_load_counter;
   logic              r_stop;
   logic              r_game_over;

   logic w_overlap;
   logic w_start_edge;
   logic w_verdict;
   logic w_enter_load;
   logic w_enter_hit;
   logic w_blink_d;
   logic w_blink_entry;
   logic w_score_en;
   logic w_hit_en;
   logic w_flash_en;
   logic w_score_tc;
   logic w_hit_tc;
   logic w_flash_tc;

   assign w_overlap     = cube_px & (|wall_px);
   assign w_start_edge  = btn_start & ~r_btn_q;
   assign w_verdict     = r_hit_acc | w_overlap;

   assign w_enter_load  = (w_state_d == LOAD) && (r_state != LOAD);
   assign w_enter_hit   = (w_state_d == HIT) && (r_state != HIT);
   assign w_blink_d     = (w_state_d == HIT) || (w_state_d == OVER);
   assign w_blink_entry = w_blink_d && (w_state_d != r_state);

   assign w_score_en    = frame_tick && (r_state == PLAY);
   assign w_hit_en      = frame_tick && (r_state == HIT);
   assign w_flash_en    = frame_tick && ((r_state == HIT) || (r_state == OVER));

   frame_divider #(
      .N (SCORE_FRAMES)
   ) u_score_div (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .i_en      (w_score_en),
      .i_clear   (w_enter_load | w_enter_hit),
      .o_tc      (w_score_tc)
   );

   frame_divider #(
      .N (HIT_FRAMES)
   ) u_hit_div (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .i_en      (w_hit_en),
      .i_clear   (w_enter_hit),
      .o_tc      (w_hit_tc)
   );

   frame_divider #(
      .N (FLASH_FRAMES)
   ) u_flash_div (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .i_en      (w_flash_en),
      .i_clear   (w_blink_entry),
      .o_tc      (w_flash_tc)
   );

   always_comb begin
      w_state_d = r_state;
      w_lives_d = r_lives;
      w_score_d = r_score;
      unique case (r_state)
         IDLE, OVER: begin
            // A start edge beats a coincident frame_tick: LOAD is entered, not skipped.
            if (w_start_edge) begin
               w_state_d = LOAD;
               w_lives_d = LivesW'(LIVES);
               w_score_d = '0;
            end
         end
         LOAD: begin
            if (frame_tick) w_state_d = PLAY;
         end
         PLAY: begin
            if (frame_tick) begin
               if (w_verdict) begin
                  w_state_d = HIT;
                  w_lives_d = r_lives - LivesW'(1);
               end else if (w_score_tc) begin
                  w_score_d = score_sat_inc(r_score);
               end
            end
         end
         HIT: begin
            if (w_hit_tc) w_state_d = (r_lives == '0) ? OVER : LOAD;
         end
         default: w_state_d = IDLE;
      endcase
   end

   always_comb begin
      w_hit_acc_d = r_hit_acc | ((r_state == PLAY) & w_overlap);
      if (frame_tick) w_hit_acc_d = 1'b0;
      // Blink phase restarts high on entry to HIT/OVER and is held high everywhere else.
      w_flash_d = 1'b1;
      if (w_blink_d && !w_blink_entry) w_flash_d = r_flash ^ w_flash_tc;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_btn_q   <= 1'b0;
         r_hit_acc <= 1'b0;
         r_lives   <= LivesW'(LIVES);
         r_score   <= '0;
         r_flash   <= 1'b1;
      end else begin
         r_state   <= w_state_d;
         r_btn_q   <= btn_start;
         r_hit_acc <= w_hit_acc_d;
         r_lives   <= w_lives_d;
         r_score   <= w_score_d;
         r_flash   <= w_flash_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_start_machine <= 1'b0;
         r_load_counter  <= 1'b1;
         r_stop          <= 1'b1;
         r_game_over     <= 1'b0;
      end else begin
         r_start_machine <= (r_state == PLAY) || (r_state == HIT);
         r_load_counter  <= (r_state == IDLE) || (r_state == LOAD);
         r_stop          <= (r_state == IDLE) || (r_state == LOAD) || (r_state == PLAY);
         r_game_over     <= (r_state == OVER);
      end
   end

   assign start_machine = r_start_machine;
   assign load_counter  = r_load_counter;
   assign stop          = r_stop;
   assign flash         = r_flash;
   assign lives         = r_lives;
   assign score         = r_score;
   assign game_over     = r_game_over;

endmodule

// File: tb/tb_wall_collision_monitor.sv
// Scoreboard bench for wall_collision_monitor: expected output snapshots are queued as each
// stimulus phase is issued and compared once the phase has been applied.
module tb_wall_collision_monitor;

   localparam int NW = 4;
   localparam int FP = 20;

   logic          clk;
   logic          reset_n;
   logic          frame_tick;
   logic          btn_start;
   logic [NW-1:0] wall_px;
   logic          cube_px;
   logic          start_machine;
   logic          load_counter;
   logic          stop;
   logic          flash;
   logic [2:0]    lives;
   logic [7:0]    score;
   logic          game_over;

   typedef struct {
      string tag;
      int    sm;
      int    lc;
      int    st;
      int    fl;
      int    lv;
      int    sc;
      int    go;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   wall_collision_monitor #(
      .NUM_WALLS    (NW),
      .LIVES        (3),
      .SCORE_FRAMES (60),
      .HIT_FRAMES   (120),
      .FLASH_FRAMES (8)
   ) u_dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .frame_tick    (frame_tick),
      .btn_start     (btn_start),
      .wall_px       (wall_px),
      .cube_px       (cube_px),
      .start_machine (start_machine),
      .load_counter  (load_counter),
      .stop          (stop),
      .flash         (flash),
      .lives         (lives),
      .score         (score),
      .game_over     (game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #10000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input int sm, input int lc, input int st,
                             input int fl, input int lv, input int sc, input int go);
      exp_t e;
      e.tag = tag; e.sm = sm; e.lc = lc; e.st = st; e.fl = fl;
      e.lv = lv; e.sc = sc; e.go = go;
      exp_q.push_back(e);
   endtask

   task automatic compare_out();
      exp_t e;
      if (exp_q.size() == 0) begin
         check_val("scoreboard_empty", 0, 1);
         return;
      end
      e = exp_q.pop_front();
      check_val({e.tag, ".start_machine"}, int'(start_machine), e.sm);
      check_val({e.tag, ".load_counter"},  int'(load_counter),  e.lc);
      check_val({e.tag, ".stop"},          int'(stop),          e.st);
      check_val({e.tag, ".flash"},         int'(flash),         e.fl);
      check_val({e.tag, ".lives"},         int'(lives),         e.lv);
      check_val({e.tag, ".score"},         int'(score),         e.sc);
      check_val({e.tag, ".game_over"},     int'(game_over),     e.go);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      step();
      step();
   endtask

   // One frame of FP cycles ending in frame_tick; harmless wall-only and cube-only pixels are
   // always present, real overlaps are injected mid-frame and/or on the tick cycle.
   task automatic do_frame(input bit mid_hit, input bit tick_hit, input bit btn_tick,
                           input int wall);
      logic [NW-1:0] hit_mask;
      hit_mask = NW'(1) << wall;
      for (int c = 0; c < FP; c++) begin
         frame_tick = (c == FP - 1);
         btn_start  = btn_tick && (c == FP - 1);
         cube_px    = 1'b0;
         wall_px    = '0;
         if (c == 3) wall_px = 4'b1011;
         if (c == 5) cube_px = 1'b1;
         if ((mid_hit && c == FP / 2) || (tick_hit && c == FP - 1)) begin
            cube_px = 1'b1;
            wall_px = hit_mask;
         end
         step();
      end
      frame_tick = 1'b0;
      btn_start  = 1'b0;
      cube_px    = 1'b0;
      wall_px    = '0;
   endtask

   task automatic clean_frames(input int n);
      for (int i = 0; i < n; i++) do_frame(1'b0, 1'b0, 1'b0, 0);
   endtask

   task automatic press_btn();
      btn_start = 1'b1;
      step();
      btn_start = 1'b0;
      step();
   endtask

   initial begin
      reset_n    = 1'b0;
      frame_tick = 1'b0;
      btn_start  = 1'b0;
      wall_px    = '0;
      cube_px    = 1'b0;
      step();
      step();
      expect_out("reset", 0, 1, 1, 1, 3, 0, 0);
      compare_out();
      reset_n = 1'b1;

      // Idle, including an overlap that must be ignored.
      expect_out("idle", 0, 1, 1, 1, 3, 0, 0);
      do_frame(1'b1, 1'b1, 1'b0, 1);
      clean_frames(2);
      settle();
      compare_out();

      // Start edge coinciding with frame_tick enters LOAD only.
      expect_out("start_on_tick_load", 0, 1, 1, 1, 3, 0, 0);
      do_frame(1'b0, 1'b0, 1'b1, 0);
      settle();
      compare_out();

      expect_out("play_entry", 1, 0, 1, 1, 3, 0, 0);
      clean_frames(1);
      settle();
      compare_out();

      expect_out("play_59", 1, 0, 1, 1, 3, 0, 0);
      for (int i = 0; i < 59; i++) begin
         clean_frames(1);
         check_val("stop_in_play", int'(stop), 1);
      end
      compare_out();

      expect_out("play_60", 1, 0, 1, 1, 3, 1, 0);
      clean_frames(1);
      settle();
      compare_out();

      expect_out("play_120", 1, 0, 1, 1, 3, 2, 0);
      for (int i = 0; i < 60; i++) begin
         clean_frames(1);
         check_val("stop_in_play", int'(stop), 1);
      end
      settle();
      compare_out();

      // Single-cycle mid-frame overlap on wall 2.
      expect_out("hit1_entry", 1, 0, 0, 1, 2, 2, 0);
      do_frame(1'b1, 1'b0, 1'b0, 2);
      settle();
      compare_out();

      expect_out("hit1_f7", 1, 0, 0, 1, 2, 2, 0);
      press_btn();
      clean_frames(7);
      compare_out();
      expect_out("hit1_f8", 1, 0, 0, 0, 2, 2, 0);
      clean_frames(1);
      settle();
      compare_out();
      expect_out("hit1_f16", 1, 0, 0, 1, 2, 2, 0);
      clean_frames(8);
      settle();
      compare_out();
      expect_out("hit1_f119", 1, 0, 0, 1, 2, 2, 0);
      clean_frames(103);
      settle();
      compare_out();
      expect_out("hit1_to_load", 0, 1, 1, 1, 2, 2, 0);
      clean_frames(1);
      settle();
      compare_out();

      // Overlaps during LOAD are ignored.
      expect_out("load_overlap_ignored", 1, 0, 1, 1, 2, 2, 0);
      do_frame(1'b1, 1'b1, 1'b0, 1);
      clean_frames(1);
      settle();
      compare_out();

      // Overlap only in the frame_tick cycle counts.
      expect_out("tick_only_hit", 1, 0, 0, 1, 1, 2, 0);
      do_frame(1'b0, 1'b1, 1'b0, 0);
      settle();
      compare_out();

      expect_out("hit2_overlap_ignored", 0, 1, 1, 1, 1, 2, 0);
      for (int i = 0; i < 5; i++) do_frame(1'b1, 1'b1, 1'b0, 3);
      clean_frames(115);
      settle();
      compare_out();

      expect_out("hit3_entry", 1, 0, 0, 1, 0, 2, 0);
      clean_frames(1);
      do_frame(1'b1, 1'b0, 1'b0, 3);
      settle();
      compare_out();

      expect_out("over_entry", 0, 0, 0, 1, 0, 2, 1);
      clean_frames(120);
      settle();
      compare_out();
      expect_out("over_f8", 0, 0, 0, 0, 0, 2, 1);
      clean_frames(8);
      settle();
      compare_out();

      expect_out("restart_load", 0, 1, 1, 1, 3, 0, 0);
      press_btn();
      settle();
      compare_out();

      // Collision on the 60th PLAY tick beats the score increment.
      expect_out("hit_beats_score", 1, 0, 0, 1, 2, 0, 0);
      clean_frames(60);
      do_frame(1'b1, 1'b0, 1'b0, 2);
      settle();
      compare_out();

      expect_out("hit_pre_reset", 1, 0, 0, 0, 2, 0, 0);
      clean_frames(8);
      settle();
      compare_out();

      // One-cycle reset mid-HIT.
      expect_out("reset_in_hit", 0, 1, 1, 1, 3, 0, 0);
      reset_n = 1'b0;
      step();
      compare_out();
      reset_n = 1'b1;
      expect_out("idle_after_reset", 0, 1, 1, 1, 3, 0, 0);
      clean_frames(2);
      settle();
      compare_out();

      if (exp_q.size() != 0) check_val("scoreboard_leftover", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wall_collision_monitor.md
# wall_collision_monitor

Game-control stage directly upstream of the moving-wall line generators. It watches the rendered wall pixels and the player-cube pixel, and detects a cube/wall overlap once per frame. It runs the play/hit/game-over sequence and drives the control inputs that every wall stage consumes: `start_machine`, `load_counter`, `flash` and `stop`. It also keeps the score and lives.

## Interface
Parameters:
- `NUM_WALLS`, 4: number of wall pixel inputs.
- `LIVES`, 3: lives loaded on game start, range 1..7.
- `SCORE_FRAMES`, 60: frames of survival per score point.
- `HIT_FRAMES`, 120: length of the hit/flash phase in frames.
- `FLASH_FRAMES`, 8: frames per `flash` half-period.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  pixel clock, same domain as the wall stages.
- `reset_n`  in  1  synchronous active-low reset.
- `frame_tick`  in  1  one-`clk` pulse at end of visible frame.
- `btn_start`  in  1  debounced, synchronized start button level.
- `wall_px`  in  NUM_WALLS  per-wall pixel-active (the `sha` outputs), valid every `clk`.
- `cube_px`  in  1  player cube pixel-active, same pixel as `wall_px`.
- `start_machine`  out  1  enables wall motion state machines.
- `load_counter`  out  1  reloads wall gap position.
- `stop`  out  1  1 = walls run and draw steadily; 0 = walls frozen and gated by `flash`.
- `flash`  out  1  blink enable for frozen walls.
- `lives`  out  3  remaining lives.
- `score`  out  8  frames-survived score, saturating.
- `game_over`  out  1  high in OVER.

## Operation
States are IDLE, LOAD, PLAY, HIT and OVER. Outputs per state:
- IDLE: `start_machine`=0, `load_counter`=1, `stop`=1, `flash`=1.
- LOAD: `start_machine`=0, `load_counter`=1, `stop`=1, `flash`=1.
- PLAY: `start_machine`=1, `load_counter`=0, `stop`=1, `flash`=1.
- HIT: `start_machine`=1, `load_counter`=0, `stop`=0; `flash` toggles.
- OVER: `start_machine`=0, `load_counter`=0, `stop`=0; `flash` toggles.

Transitions:
- IDLE → LOAD on a `btn_start` rising edge. LOAD also reloads `lives`=LIVES and clears `score`.
- LOAD → PLAY on the next `frame_tick`. This guarantees `load_counter` is high across at least one full frame boundary.
- PLAY → HIT on a `frame_tick` when that frame saw a collision. The same edge decrements `lives`.
- HIT → LOAD after HIT_FRAMES `frame_tick`s when `lives`≠0; HIT → OVER when `lives`=0.
- OVER → LOAD on a `btn_start` rising edge, with the same reload and clear as IDLE → LOAD.

Collision detection:
- Per-pixel overlap is `cube_px & |wall_px`.
- Sticky `hit_acc` is set by any overlap while in PLAY and cleared on every `frame_tick`.
- Frame verdict = `hit_acc` | overlap in the `frame_tick` cycle itself.

Score and flash:
- Frame counter counts `frame_tick`s in PLAY.
- At SCORE_FRAMES it wraps to 0 and `score` increments; `score` saturates at 255.
- The counter clears on entry to LOAD and HIT.
- `flash` toggles every FLASH_FRAMES `frame_tick`s in HIT and OVER, starting at 1 on entry. It is forced to 1 elsewhere.

Start edge:
- `btn_start` is registered once; the edge is `btn_start & ~btn_q`.
- The edge is ignored in LOAD, PLAY and HIT.

## Timing
- Reset values (`reset_n`=0 at a `clk` edge): state IDLE, `lives`=LIVES, `score`=0, `flash`=1, `stop`=1, `load_counter`=1, `start_machine`=0, `game_over`=0, all counters 0, `hit_acc`=0, `btn_q`=0.
- All outputs are registered and change only on `clk` edges.
- State changes take effect on the `clk` edge that samples `frame_tick` (or the start edge); outputs reflect the new state one cycle later.
- A collision in the final frame of PLAY wins over a score increment: on that `frame_tick` the score is not incremented.
- When `frame_tick` and a start edge coincide in IDLE or OVER, the start edge is taken and the machine enters LOAD; the `frame_tick` does not also advance it to PLAY.
- Reset mid-game returns to IDLE within one cycle, with no further `lives` decrement.
- Overlaps seen in LOAD, HIT, IDLE and OVER never set `hit_acc`.

## Structure
- Shared package `wild_cube_pkg`: state enum `game_state_t` {IDLE, LOAD, PLAY, HIT, OVER}, score width 8, lives width 3.
- One sub-module, `frame_divider`: a `frame_tick`-enabled modulo-N counter with clear and a terminal-count pulse. It is instantiated three times: score, hit length and flash period.

## Test plan
- Reset, then idle 3 frames → outputs `start_machine`=0, `load_counter`=1, `stop`=1, `flash`=1, `lives`=3, `score`=0.
- `btn_start` pulse, no overlap for 121 frames → PLAY reached after 1 frame; `score`=2 at frame 121; `stop`=1 throughout PLAY.
- Single-cycle overlap on `wall_px[2]` mid-frame in PLAY → HIT at the next `frame_tick`; `lives`=2; `stop`=0; `flash` toggles every 8 frames; LOAD after 120 frames, then PLAY.
- Three separate collisions → OVER after the third HIT; `game_over`=1, `lives`=0; `btn_start` then gives LOAD with `lives`=3 and `score`=0.
- Overlap present only on the `frame_tick` cycle → counted as a hit; the same overlap during HIT or LOAD → ignored.
- `reset_n` low for one cycle during HIT → IDLE next cycle with `lives`=3 and `flash`=1.
